// File: rtl/bkm_step_sequencer.sv
// bkm_step_sequencer: iteration sequencer for the BKM datapath.
// Latches an operation (mode, format, X_0, Y_0, iteration count) from the
// front-end. It presents the current iterate and index n to the combinational
// data-step slice, and captures the slice's next iterate on each enabled cycle.
// The final X/Y is returned through a valid/ready handshake.
//
// Optional feature macro: BKM_SEQ_ABORT_EN
//   defined   -> adds input 'abort'. In RUN or DONE it drops the operation and
//                returns to IDLE.
//   undefined -> no abort port; every operation runs to handshake completion.
//
// Result handshake: res_X/res_Y are valid while out_valid=1, and they stay
// stable until the transfer. A transfer happens on a rising clk edge where
// out_valid && out_ready. out_valid never depends combinationally on
// out_ready, and enable has no effect on the handshake.
// Start handshake: an operation is accepted on a rising edge where
// start && start_ready. start is not queued while start_ready=0.
module bkm_step_sequencer #(
  parameter int W     = 64,
  parameter int LOG2N = 6
) (
  input  logic             clk,
  input  logic             srst,
`ifdef BKM_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             enable,
  input  logic             start,
  output logic             start_ready,
  input  logic             mode,
  input  logic [1:0]       format,
  input  logic [LOG2N-1:0] n_iter,
  input  logic [W-1:0]     X_0,
  input  logic [W-1:0]     Y_0,
  output logic             step_mode,
  output logic [1:0]       step_format,
  output logic [LOG2N-1:0] step_n,
  output logic [W-1:0]     step_X_n,
  output logic [W-1:0]     step_Y_n,
  input  logic [W-1:0]     step_X_np1,
  input  logic [W-1:0]     step_Y_np1,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     res_X,
  output logic [W-1:0]     res_Y,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [LOG2N-1:0] n_iter_q;
  logic             last_step;
  logic             abort_w;

`ifdef BKM_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // The current step is the final one when n reaches the latched count minus one.
  assign last_step = (step_n == (n_iter_q - LOG2N'(1)));

  // State register; srst dominates every other request.
  always_ff @(posedge clk) begin
    if (srst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, count in RUN, hand off in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (n_iter != '0) ? S_RUN : S_DONE;
      S_RUN: begin
        if (abort_w)                 state_d = S_IDLE;
        else if (enable && last_step) state_d = S_DONE;
      end
      S_DONE: if (abort_w || out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state only.
  always_comb begin
    start_ready = (state_q == S_IDLE);
    busy        = (state_q == S_RUN) || (state_q == S_DONE);
    out_valid   = (state_q == S_DONE);
    dbg_state   = state_q;
  end

  // Operand, index and iterate registers. They are loaded at accept and
  // advanced on enabled RUN cycles. They hold otherwise, including across
  // abort and after the result handshake.
  always_ff @(posedge clk) begin
    if (srst) begin
      step_mode   <= 1'b0;
      step_format <= 2'b00;
      step_n      <= '0;
      step_X_n    <= '0;
      step_Y_n    <= '0;
      n_iter_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            step_mode   <= mode;
            step_format <= format;
            n_iter_q    <= n_iter;
            step_X_n    <= X_0;
            step_Y_n    <= Y_0;
            step_n      <= '0;
          end
        end
        S_RUN: begin
          if (enable && !abort_w) begin
            step_X_n <= step_X_np1;
            step_Y_n <= step_Y_np1;
            if (!last_step) step_n <= step_n + LOG2N'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The result is read straight from the iterate registers, which are frozen in DONE.
  assign res_X = step_X_n;
  assign res_Y = step_Y_n;

endmodule

// File: tb/tb_bkm_step_sequencer.sv
// Testbench for bkm_step_sequencer.
// The datapath stub computes X_np1 = X_n + 1 and Y_np1 = Y_n + 2, so that
// after k steps X = X_0 + k and Y = Y_0 + 2k.
module tb_bkm_step_sequencer;
  localparam int W     = 64;
  localparam int LOG2N = 6;

  logic             clk = 1'b0;
  logic             srst;
  logic             enable;
  logic             start;
  logic             start_ready;
  logic             mode;
  logic [1:0]       format;
  logic [LOG2N-1:0] n_iter;
  logic [W-1:0]     X_0, Y_0;
  logic             step_mode;
  logic [1:0]       step_format;
  logic [LOG2N-1:0] step_n;
  logic [W-1:0]     step_X_n, step_Y_n, step_X_np1, step_Y_np1;
  logic             busy, out_valid, out_ready;
  logic [W-1:0]     res_X, res_Y;
  logic [1:0]       dbg_state;
`ifdef BKM_SEQ_ABORT_EN
  logic             abort;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_qy[$];

  bkm_step_sequencer #(.W(W), .LOG2N(LOG2N)) dut (
    .clk(clk), .srst(srst),
`ifdef BKM_SEQ_ABORT_EN
    .abort(abort),
`endif
    .enable(enable), .start(start), .start_ready(start_ready),
    .mode(mode), .format(format), .n_iter(n_iter), .X_0(X_0), .Y_0(Y_0),
    .step_mode(step_mode), .step_format(step_format), .step_n(step_n),
    .step_X_n(step_X_n), .step_Y_n(step_Y_n),
    .step_X_np1(step_X_np1), .step_Y_np1(step_Y_np1),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .res_X(res_X), .res_Y(res_Y), .dbg_state(dbg_state)
  );

  // ---------------- clock / datapath stub ----------------
  always #5 clk = ~clk;

  always_comb begin
    step_X_np1 = step_X_n + 64'd1;
    step_Y_np1 = step_Y_n + 64'd2;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic scramble_inputs();
    mode   = 1'($urandom);
    format = 2'($urandom);
    n_iter = LOG2N'($urandom);
    X_0    = {$urandom, $urandom};
    Y_0    = {$urandom, $urandom};
  endtask

  // Present one operation for a single accept edge. The operand inputs are
  // then scrambled, so the bench also sees whether they were latched properly.
  task automatic start_op(input logic [LOG2N-1:0] n, input logic [W-1:0] x0,
                          input logic [W-1:0] y0, input logic md, input logic [1:0] fm);
    mode = md; format = fm; n_iter = n; X_0 = x0; Y_0 = y0;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble_inputs();
  endtask

  // Count the edges from the accept edge until out_valid is seen, within a bounded budget.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    logic [LOG2N-1:0] n;
    logic [W-1:0]     x0, y0, ex, ey;
    logic [LOG2N-1:0] en;
    int               lat;
  } vec_t;

  vec_t vecs[4];
  int   lat;

  initial begin
    srst = 1'b1; enable = 1'b0; start = 1'b0; out_ready = 1'b0;
`ifdef BKM_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    scramble_inputs();
    tick(); tick();

    // ---------------- reset state ----------------
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_step_n", 64'(step_n), 64'd0);
    chk("rst_X", step_X_n, 64'd0);
    chk("rst_Y", step_Y_n, 64'd0);
    chk("rst_mode_fmt", 64'({step_mode, step_format}), 64'd0);
    srst = 1'b0;
    tick();

    // ---------------- table vectors, enable held high ----------------
    vecs[0] = '{n: 6'd5,  x0: 64'd100, y0: 64'd7, ex: 64'd105, ey: 64'd17, en: 6'd4, lat: 6};
    vecs[1] = '{n: 6'd0,  x0: 64'd42,  y0: 64'd9, ex: 64'd42,  ey: 64'd9,  en: 6'd0, lat: 1};
    vecs[2] = '{n: 6'd1,  x0: 64'd0,   y0: 64'd0, ex: 64'd1,   ey: 64'd2,  en: 6'd0, lat: 2};
    vecs[3] = '{n: 6'd63, x0: 64'hFFFF_FFFF_FFFF_FFF0, y0: 64'd5,
                ex: 64'h2F, ey: 64'd131, en: 6'd62, lat: 64};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_op(vecs[i].n, vecs[i].x0, vecs[i].y0, 1'b1, 2'd2);
      wait_valid(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_res_X", i), res_X, vecs[i].ex);
      chk($sformatf("vec%0d_res_Y", i), res_Y, vecs[i].ey);
      chk($sformatf("vec%0d_step_n", i), 64'(step_n), 64'(vecs[i].en));
      chk($sformatf("vec%0d_mode_fmt", i), 64'({step_mode, step_format}), 64'h6);
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("vec%0d_idle", i), 64'({start_ready, out_valid, busy}), 64'b100);
      chk($sformatf("vec%0d_res_hold", i), res_X, vecs[i].ex);
    end

    // ---------------- enable gating: 1,0,0,1,1,0,1 with n_iter=4 ----------------
    begin
      logic [6:0]       pat;
      logic [LOG2N-1:0] exp_n[7];
      pat = 7'b1011001;  // applied LSB first
      exp_n = '{6'd1, 6'd1, 6'd1, 6'd2, 6'd3, 6'd3, 6'd3};
      enable = 1'b0;
      start_op(6'd4, 64'd10, 64'd20, 1'b0, 2'd1);
      for (int k = 0; k < 7; k++) begin
        enable = pat[k];
        tick();
        chk($sformatf("gate_step_n_%0d", k), 64'(step_n), 64'(exp_n[k]));
        chk($sformatf("gate_valid_%0d", k), 64'(out_valid), (k == 6) ? 64'd1 : 64'd0);
      end
      chk("gate_res_X", res_X, 64'd14);
      chk("gate_res_Y", res_Y, 64'd28);
    end

    // ---------------- DONE stall with ignored start, then coincident start+ready ----------------
    for (int k = 0; k < 10; k++) begin
      start = (k % 3 == 0);
      enable = 1'($urandom);
      tick();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_start_ready", 64'(start_ready), 64'd0);
      chk("stall_res_X", res_X, 64'd14);
      chk("stall_res_Y", res_Y, 64'd28);
    end
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("coinc_idle", 64'({start_ready, out_valid, busy}), 64'b100);
    tick();
    chk("coinc_still_idle", 64'({start_ready, busy}), 64'b10);

    // ---------------- srst in RUN at step_n=3 of n_iter=8 ----------------
    enable = 1'b1;
    start_op(6'd8, 64'd500, 64'd600, 1'b1, 2'd3);
    tick(); tick(); tick();
    chk("srst_pre_step_n", 64'(step_n), 64'd3);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("srst_idle", 64'({start_ready, out_valid, busy}), 64'b100);
    chk("srst_step_n", 64'(step_n), 64'd0);
    chk("srst_X", step_X_n, 64'd0);
    chk("srst_mode_fmt", 64'({step_mode, step_format}), 64'd0);
    start_op(6'd3, 64'd1000, 64'd1, 1'b0, 2'd0);
    wait_valid(lat);
    chk("srst_after_lat", 64'(lat), 64'd4);
    chk("srst_after_res_X", res_X, 64'd1003);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef BKM_SEQ_ABORT_EN
    // ---------------- abort at step_n=2 of n_iter=6 ----------------
    start_op(6'd6, 64'd300, 64'd30, 1'b0, 2'd0);
    tick(); tick();
    chk("abort_pre_step_n", 64'(step_n), 64'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 64'({start_ready, out_valid, busy}), 64'b100);
    chk("abort_X_hold", step_X_n, 64'd302);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_valid", 64'(out_valid), 64'd0);
    end
    start_op(6'd1, 64'd77, 64'd8, 1'b0, 2'd0);
    wait_valid(lat);
    chk("abort_next_lat", 64'(lat), 64'd2);
    chk("abort_next_res_X", res_X, 64'd78);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    // ---------------- randomized operations vs reference model ----------------
    // The model counts the enabled RUN cycles still owed. While any are
    // owed, the index and iterate equal the number of steps taken so far.
    // A result is owed exactly when none remain.
    for (int op = 0; op < 40; op++) begin
      logic [LOG2N-1:0] n;
      logic [W-1:0]     x0, y0;
      logic             md;
      logic [1:0]       fm;
      int               rem, cyc;
      logic             en;
      n  = LOG2N'($urandom_range(0, 12));
      x0 = {$urandom, $urandom};
      y0 = {$urandom, $urandom};
      md = 1'($urandom);
      fm = 2'($urandom);
      exp_q.push_back(x0 + 64'(n));
      exp_qy.push_back(y0 + 64'(2 * int'(n)));
      chk("rnd_ready_before", 64'(start_ready), 64'd1);
      enable = 1'($urandom);
      start_op(n, x0, y0, md, fm);
      rem = int'(n);
      cyc = 0;
      while (rem > 0 && cyc < 300) begin
        chk("rnd_valid_run", 64'(out_valid), 64'd0);
        chk("rnd_step_n", 64'(step_n), 64'(int'(n) - rem));
        chk("rnd_step_X", step_X_n, x0 + 64'(int'(n) - rem));
        chk("rnd_mode_fmt", 64'({step_mode, step_format}), 64'({md, fm}));
        en = ($urandom_range(0, 3) != 0);
        enable = en;
        tick();
        if (en) rem--;
        cyc++;
      end
      chk("rnd_valid_done", 64'(out_valid), 64'd1);
      for (int s = $urandom_range(0, 3); s > 0; s--) begin
        enable = 1'($urandom);
        tick();
        chk("rnd_stall_valid", 64'(out_valid), 64'd1);
      end
      if (exp_q.size() > 0) begin
        chk("rnd_res_X", res_X, exp_q.pop_front());
        chk("rnd_res_Y", res_Y, exp_qy.pop_front());
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("rnd_idle_after", 64'({start_ready, out_valid}), 64'b10);
      if ($urandom_range(0, 1) == 1) tick();
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
